// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder
//   Round-robin arbiter with a registered one-hot grant and its binary index,
//   handed to a consumer over a valid/ready handshake at one grant per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         [NUM_CLIENTS-1:0] request vector
//   gnt_valid   grant register holds a grant
//   gnt_ready   consumer accepts the grant this cycle
//   gnt_onehot  [NUM_CLIENTS-1:0] registered one-hot grant
//   gnt_index   [IDX_W-1:0] binary index of gnt_onehot
//   err         sticky encoder-check error
//
// Build option
//   ENC_CHECK_EN : adds a reference priority encoder plus a one-hot check on
//                  the grant register. Mismatches set err (sticky), and
//                  assertions flag them. When the macro is undefined, err is 0.

module rr_grant_encoder #(
  parameter  int NUM_CLIENTS = 16,
  localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic                   gnt_valid,
  input  logic                   gnt_ready,
  output logic [NUM_CLIENTS-1:0] gnt_onehot,
  output logic [IDX_W-1:0]       gnt_index,
  output logic                   err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  // mask[b][i] = bit b of i. These are elaboration-time constants, so the
  // encoder reduces to IDX_W wide OR gates.
  typedef logic [IDX_W-1:0][NUM_CLIENTS-1:0] mask_t;

  function automatic mask_t gen_masks();
    mask_t m;
    m = '0;
    for (int b = 0; b < IDX_W; b++)
      for (int i = 0; i < NUM_CLIENTS; i++)
        m[b][i] = ((i >> b) & 1) == 1;
    return m;
  endfunction

  localparam mask_t IDX_MASK = gen_masks();

  function automatic logic [IDX_W-1:0] enc(input logic [NUM_CLIENTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    for (int b = 0; b < IDX_W; b++) idx[b] = |(oh & IDX_MASK[b]);
    return idx;
  endfunction

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] oh_q, oh_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  logic [NUM_CLIENTS-1:0] ge_mask, req_hi, pick_src, sel_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic                   load;

  assign gnt_valid  = (state_q == FULL);
  assign gnt_onehot = oh_q;
  assign gnt_index  = idx_q;

  // Rotating priority without a loop. Search the requests at or above ptr
  // first. If none are set, fall back to the full vector, which is the
  // wrap-around case. x & -x isolates the lowest set bit.
  always_comb begin
    ge_mask  = {NUM_CLIENTS{1'b1}} << ptr_q;
    req_hi   = req & ge_mask;
    pick_src = (|req_hi) ? req_hi : req;
    sel_oh   = pick_src & (~pick_src + NUM_CLIENTS'(1));
    sel_idx  = enc(sel_oh);
    load     = (|req) && (!gnt_valid || gnt_ready);
  end

  always_comb begin
    state_d = state_q;
    oh_d    = oh_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = FULL;
      oh_d    = sel_oh;
      idx_d   = sel_idx;
      // Wrap explicitly so a non-power-of-2 client count never leaves ptr
      // pointing past the last client.
      ptr_d   = (sel_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : sel_idx + IDX_W'(1);
    end else if (gnt_valid && gnt_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      oh_q    <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ENC_CHECK_EN
  logic [IDX_W-1:0] ref_idx;
  logic             oh_ok;
  logic             err_q, err_d;

  // The reference uses a plain priority encoder, which is structurally
  // different from the mask encoder it checks.
  always_comb begin
    ref_idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--)
      if (oh_q[i]) ref_idx = i[IDX_W-1:0];
    oh_ok = (oh_q != '0) && ((oh_q & (oh_q - NUM_CLIENTS'(1))) == '0);
    err_d = err_q | (gnt_valid && (!oh_ok || (ref_idx != idx_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid |-> oh_ok);
  a_index: assert property (@(posedge clk) disable iff (!rst_n)
    gnt_valid |-> (ref_idx == idx_q));
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_encoder.sv
module tb_rr_grant_encoder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         gnt_valid;
  logic         gnt_ready;
  logic [N-1:0] gnt_onehot;
  logic [2:0]   gnt_index;
  logic         err;

  rr_grant_encoder #(.NUM_CLIENTS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .gnt_onehot (gnt_onehot),
    .gnt_index  (gnt_index),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] oh;
    logic [2:0]   idx;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic         v;
    logic [N-1:0] oh;
    logic [2:0]   idx;
  } vec_t;

  exp_t sbq[$];
  logic m_valid;
  int   m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
  endtask

  // Apply one cycle of stimulus. Outputs are stable from the previous edge,
  // so the handshake is scored before the edge. The model then predicts the
  // next grant and pushes it onto the queue.
  task automatic cyc(input logic [N-1:0] r, input logic rd);
    exp_t e;
    int   sel;
    bit   found;
    req       = r;
    gnt_ready = rd;
    #1;
    chk("gnt_valid", 32'(gnt_valid), 32'(m_valid));
    chk("err", 32'(err), 32'd0);
    if (gnt_valid && rd) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_empty: got a grant, expected none at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("sb_onehot", 32'(gnt_onehot), 32'(e.oh));
        chk("sb_index", 32'(gnt_index), 32'(e.idx));
      end
    end
    if ((r != '0) && (!m_valid || rd)) begin
      found = 0;
      sel   = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && r[j]) begin
          found = 1;
          sel   = j;
        end
      end
      e.oh  = '0;
      e.oh[sel] = 1'b1;
      e.idx = 3'(sel);
      sbq.push_back(e);
      m_ptr   = (sel + 1) % N;
      m_valid = 1'b1;
    end else if (rd) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [N-1:0] oh,
                         input logic [2:0] idx);
    chk({nm, "_valid"}, 32'(gnt_valid), 32'(v));
    chk({nm, "_onehot"}, 32'(gnt_onehot), 32'(oh));
    chk({nm, "_index"}, 32'(gnt_index), 32'(idx));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected it to finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[14];
    logic [N-1:0] one;

    one = 8'h01;
    for (int i = 0; i < 11; i++)
      tbl[i] = '{req: 8'hFF, rdy: 1'b1, v: 1'b1, oh: one << (i % N), idx: 3'(i % N)};
    // ptr is now 3, which gives the fairness pattern.
    tbl[11] = '{req: 8'b1000_0100, rdy: 1'b1, v: 1'b1, oh: 8'h80, idx: 3'd7};
    tbl[12] = '{req: 8'b1000_0100, rdy: 1'b1, v: 1'b1, oh: 8'h04, idx: 3'd2};
    tbl[13] = '{req: 8'b1000_0100, rdy: 1'b1, v: 1'b1, oh: 8'h80, idx: 3'd7};

    rst_n = 1'b0; req = '0; gnt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 8'h00, 3'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Idle
    for (int i = 0; i < 20; i++) begin
      cyc(8'h00, 1'(i & 1));
      chk_out("idle", 1'b0, 8'h00, 3'd0);
    end

    // Full sweep + fairness
    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].oh, tbl[i].idx);
    end

    // Backpressure: issue index 5, stall 5 cycles, then resume at >= 6
    cyc(8'h20, 1'b1);
    chk_out("bp_issue", 1'b1, 8'h20, 3'd5);
    for (int i = 0; i < 5; i++) begin
      cyc((i & 1) ? 8'hFF : 8'h01, 1'b0);
      chk_out("bp_stall", 1'b1, 8'h20, 3'd5);
    end
    cyc(8'hFF, 1'b1);
    chk_out("bp_resume", 1'b1, 8'h40, 3'd6);
    cyc(8'h01, 1'b1);
    chk_out("wrap_low", 1'b1, 8'h01, 3'd0);
    cyc(8'h00, 1'b1);
    chk_out("drain", 1'b0, 8'h01, 3'd0);

    // Reset with index 6 pending
    cyc(8'h40, 1'b1);
    chk_out("rst_pend", 1'b1, 8'h40, 3'd6);
    gnt_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 8'h00, 3'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst_hold", 1'b0, 8'h00, 3'd0);
    rst_n = 1'b1;
    cyc(8'b0101_0000, 1'b1);
    chk_out("rst_first", 1'b1, 8'h10, 3'd4);

    // Random traffic, scored through the scoreboard
    for (int i = 0; i < 10000; i++)
      cyc(N'($urandom), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
